// File: rtl/input_debounce_pkg.sv
// -----------------------------------------------------------------------------
// input_debounce_pkg
// Shared constants and elaboration-time helpers for the input debouncer.
//   - clog2_ceil / cnt_width : counter sizing so the stability counter can
//                              never wrap
//   - calc_n                 : stability interval in clock cycles, never below 1
//   - CH_*                   : channel index of each physical input
//   - chan_state_e           : per-channel debounce state
// -----------------------------------------------------------------------------
package input_debounce_pkg;

    // Channel assignment on inRaw / outStable / outRise / outFall.
    localparam int unsigned CH_PEDESTRIAN = 0;
    localparam int unsigned CH_TRAFFIC    = 1;
    localparam int unsigned CH_MODE       = 2;

    // STABLE: synchronized input equals the debounced level.
    // PENDING: they differ and the stability counter is running.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } chan_state_e;

    // Smallest w with 2**w >= v.
    function automatic int unsigned clog2_ceil(input longint unsigned v);
        int unsigned     w;
        longint unsigned p;
        w = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            w = w + 1;
        end
        return w;
    endfunction

    // Bits needed to hold every value 0..n, at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = clog2_ceil(longint'(n) + 64'd1);
        return (w < 1) ? 1 : w;
    endfunction

    // Cycles of stability required: clk_frq/1000 * interval_ms, at least 1.
    function automatic int unsigned calc_n(input int unsigned clk_frq,
                                           input int unsigned interval_ms);
        longint unsigned n;
        n = (longint'(clk_frq) / 64'd1000) * longint'(interval_ms);
        return (n < 64'd1) ? 1 : int'(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced bit: 2-FF synchronizer, stability counter and registered
// edge pulses.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset, clears every register
//   raw_i    - raw asynchronous level
//   stable_o - debounced level
//   rise_o   - one-cycle pulse in the first cycle stable_o shows 1
//   fall_o   - one-cycle pulse in the first cycle stable_o shows 0
// -----------------------------------------------------------------------------
module debounce_channel
    import input_debounce_pkg::*;
#(
    parameter int unsigned C_N  = 1,
    parameter int unsigned C_CW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [C_CW-1:0] LAST_CNT = C_CW'(C_N - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic            rise_q;
    logic            rise_d;
    logic            fall_q;
    logic            fall_d;
    logic [C_CW-1:0] cnt_q;
    logic [C_CW-1:0] cnt_d;
    chan_state_e     state;

    // The state is implied by the synchronized input versus the debounced
    // level, so it needs no register of its own.
    assign state = (sync2_q != stable_q) ? ST_PENDING : ST_STABLE;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (state == ST_PENDING) begin
            if (cnt_q == LAST_CNT) begin
                // N consecutive differing cycles: accept the new level.
                stable_d = sync2_q;
                rise_d   = sync2_q;
                fall_d   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // In STABLE the counter falls back to zero, which also drops any
        // partially counted glitch.
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
// Debounces C_WIDTH independent switch/sensor inputs. A new level is
// accepted only after it has been seen, synchronized, for C_INTERVAL ms.
// Ports:
//   clk       - clock, C_CLK_FRQ Hz
//   rst       - asynchronous active-high reset
//   inRaw     - raw asynchronous levels (0 pedestrian, 1 traffic, 2 mode)
//   outStable - debounced levels
//   outRise   - one-cycle pulse per bit on a 0->1 change of outStable
//   outFall   - one-cycle pulse per bit on a 1->0 change of outStable
// -----------------------------------------------------------------------------
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int unsigned C_CLK_FRQ  = 100000000,
    parameter int unsigned C_INTERVAL = 10,
    parameter int unsigned C_WIDTH    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [C_WIDTH-1:0] inRaw,
    output logic [C_WIDTH-1:0] outStable,
    output logic [C_WIDTH-1:0] outRise,
    output logic [C_WIDTH-1:0] outFall
);

    localparam int unsigned C_N  = calc_n(C_CLK_FRQ, C_INTERVAL);
    localparam int unsigned C_CW = cnt_width(C_N);

    generate
        for (genvar gi = 0; gi < C_WIDTH; gi++) begin : g_ch
            debounce_channel #(
                .C_N  (C_N),
                .C_CW (C_CW)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .raw_i    (inRaw[gi]),
                .stable_o (outStable[gi]),
                .rise_o   (outRise[gi]),
                .fall_o   (outFall[gi])
            );
        end
    endgenerate

endmodule
